// File: rtl/clock_ui_controller.sv
// clock_ui_controller: button debounce, mode/select sequencing, increment auto-repeat and alarm ring control
module clock_ui_controller #(
    parameter int CLK_FREQ_HZ     = 1000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int RING_TIMEOUT_S  = 60
) (
    input  logic       clk,
    input  logic       global_reset_n,
    input  logic       btn_mode,
    input  logic       btn_select,
    input  logic       btn_inc,
    input  logic       alarm_in,
    output logic [1:0] mode_out,
    output logic [1:0] select_out,
    output logic       increment_out,
    output logic       alarm_enable_out,
    output logic       ring_out
);
    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int PW       = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int DW       = $clog2(DEBOUNCE_MS + 1);
    localparam int RMAX     = REPEAT_DELAY_MS > REPEAT_RATE_MS ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int RW       = $clog2(RMAX + 1);
    localparam int SW       = $clog2(RING_TIMEOUT_S + 1);

    typedef enum logic [1:0] {CLOCK, CLOCK_EDIT, STOPWATCH, ALARM_EDIT} mode_t;
    typedef enum logic [1:0] {P_IDLE, P_HIGH, P_LOW} pulse_t;

    logic [PW-1:0] pre;
    logic          tick;
    logic [3:0]    raw, sync1, sync2;
    logic [2:0]    db, db_q, press;
    logic [DW-1:0] db_cnt [3];
    logic          alarm_q, alarm_rise;
    logic          ev_silence, ev_mode, ev_sel, ev_inc;
    mode_t         mode, mode_nx;
    logic [1:0]    sel_nx;
    logic          en_nx, edit;
    logic          rep_active, rep_first, rep_fire;
    logic [RW-1:0] rep_cnt, lim;
    pulse_t        pst, pst_nx;
    logic [PW-1:0] pcnt;
    logic          pdone, pend, req;
    logic [9:0]    ms_cnt;
    logic [SW-1:0] sec_cnt;
    logic          sec_wrap, timeout;

    assign tick = pre == PW'(TICK_DIV - 1);
    assign raw  = {alarm_in, btn_inc, btn_select, btn_mode};

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            pre     <= '0;
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            db_q    <= '0;
            alarm_q <= 1'b0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            pre     <= tick ? '0 : pre + 1'b1;
            sync1   <= raw;
            sync2   <= sync1;
            db_q    <= db;
            alarm_q <= sync2[3];
            // a level must disagree for DEBOUNCE_MS consecutive ticks; any agreement restarts the count
            if (tick) for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db[i]) db_cnt[i] <= '0;
                else if (db_cnt[i] == DW'(DEBOUNCE_MS - 1)) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else db_cnt[i] <= db_cnt[i] + 1'b1;
            end
        end
    end

    assign press      = db & ~db_q;
    assign alarm_rise = sync2[3] & ~alarm_q;
    assign ev_silence = ring_out & |press;
    assign ev_mode    = !ring_out & press[0];
    assign ev_sel     = !ring_out & !press[0] & press[1];
    assign ev_inc     = !ring_out & (press == 3'b100);
    assign edit       = mode == CLOCK_EDIT || mode == ALARM_EDIT;

    always_comb begin
        mode_nx = mode;
        sel_nx  = select_out;
        en_nx   = alarm_enable_out;
        if (ev_mode) begin
            mode_nx = mode_t'(mode + 2'd1);
            sel_nx  = (mode_nx == CLOCK_EDIT || mode_nx == ALARM_EDIT) ? 2'd3 : 2'd0;
        end else if (ev_sel && edit) sel_nx = select_out == 2'd1 ? 2'd3 : select_out - 2'd1;
        else if (ev_inc && mode == CLOCK) en_nx = !alarm_enable_out;
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            mode             <= CLOCK;
            select_out       <= 2'd0;
            alarm_enable_out <= 1'b0;
        end else begin
            mode             <= mode_nx;
            select_out       <= sel_nx;
            alarm_enable_out <= en_nx;
        end
    end

    assign mode_out = mode;
    assign lim      = rep_first ? RW'(REPEAT_DELAY_MS) : RW'(REPEAT_RATE_MS);
    assign rep_fire = rep_active & tick & db[2] & (rep_cnt == lim - 1'b1);

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            rep_active <= 1'b0;
            rep_first  <= 1'b0;
            rep_cnt    <= '0;
        end else if (ev_inc && edit) begin
            rep_active <= 1'b1;
            rep_first  <= 1'b1;
            rep_cnt    <= '0;
        end else if (!db[2] || ev_mode || ev_sel) rep_active <= 1'b0;
        else if (rep_active && tick) begin
            rep_cnt <= rep_fire ? '0 : rep_cnt + 1'b1;
            if (rep_fire) rep_first <= 1'b0;
        end
    end

    // each pulse is one tick period high then one tick period low; a request arriving mid-pulse waits in pend
    assign req   = (ev_inc && mode != CLOCK) || rep_fire;
    assign pdone = pcnt == PW'(TICK_DIV - 1);

    always_comb begin
        pst_nx = pst;
        case (pst)
            P_IDLE:  pst_nx = (req || pend) ? P_HIGH : P_IDLE;
            P_HIGH:  pst_nx = pdone ? P_LOW : P_HIGH;
            P_LOW:   pst_nx = pdone ? P_IDLE : P_LOW;
            default: pst_nx = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            pst  <= P_IDLE;
            pcnt <= '0;
            pend <= 1'b0;
        end else begin
            pst  <= pst_nx;
            pcnt <= (pst != pst_nx || pst == P_IDLE) ? '0 : pcnt + 1'b1;
            pend <= (ev_mode || ev_sel || pst == P_IDLE) ? 1'b0 : pend | req;
        end
    end

    assign increment_out = pst == P_HIGH;
    assign sec_wrap      = tick & (ms_cnt == 10'd999);
    assign timeout       = ring_out & sec_wrap & (sec_cnt == SW'(RING_TIMEOUT_S - 1));

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            ring_out <= 1'b0;
            ms_cnt   <= '0;
            sec_cnt  <= '0;
        end else if (ev_silence || timeout || !alarm_enable_out) ring_out <= 1'b0;
        else if (alarm_rise) begin
            ring_out <= 1'b1;
            ms_cnt   <= '0;
            sec_cnt  <= '0;
        end else if (ring_out && tick) begin
            ms_cnt <= sec_wrap ? 10'd0 : ms_cnt + 10'd1;
            if (sec_wrap) sec_cnt <= sec_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_clock_ui_controller.sv
// tb_clock_ui_controller: scoreboard bench with a press-level reference model of the UI controller
module tb_clock_ui_controller;
    localparam int DEB = 2, DLY = 10, RATE = 4, RTO = 2, TICK = 1;

    logic clk = 0, rst_n = 1;
    logic b_mode = 0, b_sel = 0, b_inc = 0, alarm = 0;
    logic [1:0] mode_out, select_out;
    logic increment_out, alarm_enable_out, ring_out;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [5:0] st_q[$];
    int pulse_q[$];
    int dur_q[$];
    int m_mode = 0, m_sel = 0, m_en = 0, m_ring = 0;

    clock_ui_controller #(
        .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(DEB), .REPEAT_DELAY_MS(DLY),
        .REPEAT_RATE_MS(RATE), .RING_TIMEOUT_S(RTO)
    ) dut (
        .clk(clk), .global_reset_n(rst_n), .btn_mode(b_mode), .btn_select(b_sel),
        .btn_inc(b_inc), .alarm_in(alarm), .mode_out(mode_out), .select_out(select_out),
        .increment_out(increment_out), .alarm_enable_out(alarm_enable_out), .ring_out(ring_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event seen at cycle %0d with nothing expected", name, cyc);
    endtask

    function automatic logic [5:0] st_pack();
        return {2'(m_mode), 2'(m_sel), 1'(m_en), 1'(m_ring)};
    endfunction

    // monitor: every change of the state outputs, pulse edge and ring fall is scored against the queues
    logic [5:0] prev_st = '0, cur_st;
    logic prev_inc = 0, prev_ring = 0;
    int anchor = 0, hi_start = 0, last_fall = -100, ring_start = 0, off, dur;

    always @(negedge clk) begin
        cur_st = {mode_out, select_out, alarm_enable_out, ring_out};
        if (cur_st !== prev_st) begin
            if (st_q.size() == 0) unexpected("state change");
            else check("state", int'(cur_st), int'(st_q.pop_front()));
        end
        prev_st = cur_st;
        if (increment_out && !prev_inc) begin
            hi_start = cyc;
            check("pulse low gap", int'(cyc - last_fall >= TICK), 1);
            if (pulse_q.size() == 0) unexpected("increment pulse");
            else begin
                off = pulse_q.pop_front();
                if (off == 0) anchor = cyc;
                check("pulse offset", cyc - anchor, off);
            end
        end
        if (!increment_out && prev_inc) begin
            check("pulse width", cyc - hi_start, TICK);
            last_fall = cyc;
        end
        prev_inc = increment_out;
        if (ring_out && !prev_ring) ring_start = cyc;
        if (!ring_out && prev_ring) begin
            if (dur_q.size() == 0) unexpected("ring fall");
            else begin
                dur = dur_q.pop_front();
                if (dur >= 0) check("ring duration", cyc - ring_start, dur);
            end
        end
        prev_ring = ring_out;
    end

    task automatic set_btn(input int b, input logic v);
        if (b == 0) b_mode = v;
        else if (b == 1) b_sel = v;
        else b_inc = v;
    endtask

    // reference model acts on whole presses: one press, one rule application
    task automatic press(input int b, input int hold, input int gap);
        if (m_ring != 0) begin
            m_ring = 0;
            st_q.push_back(st_pack());
        end else if (b == 0) begin
            m_mode = (m_mode + 1) % 4;
            m_sel  = (m_mode == 1 || m_mode == 3) ? 3 : 0;
            st_q.push_back(st_pack());
        end else if (b == 1) begin
            if (m_mode == 1 || m_mode == 3) begin
                m_sel = (m_sel == 1) ? 3 : m_sel - 1;
                st_q.push_back(st_pack());
            end
        end else if (m_mode == 0) begin
            m_en = 1 - m_en;
            st_q.push_back(st_pack());
        end else if (m_mode == 2) pulse_q.push_back(0);
        else for (int o = 0; o < hold; o = (o == 0) ? DLY : o + RATE) pulse_q.push_back(o);
        @(posedge clk); #1;
        set_btn(b, 1'b1);
        repeat (hold) @(posedge clk);
        #1 set_btn(b, 1'b0);
        repeat (gap) @(posedge clk);
    endtask

    task automatic ring(input int exp_dur);
        m_ring = 1;
        st_q.push_back(st_pack());
        dur_q.push_back(exp_dur);
        if (exp_dur >= 0) begin
            m_ring = 0;
            st_q.push_back(st_pack());
        end
        @(posedge clk); #1 alarm = 1;
        repeat (5) @(posedge clk);
        #1 alarm = 0;
    endtask

    int found;

    initial begin
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset mode/select", {mode_out, select_out}, 0);
        check("reset inc/en/ring", {increment_out, alarm_enable_out, ring_out}, 0);
        rst_n = 1;
        repeat (3) @(posedge clk);

        // reset during an increment pulse
        press(0, 5, 8);
        m_mode = 0; m_sel = 0; m_en = 0; m_ring = 0;
        st_q.push_back(st_pack());
        @(posedge clk); #1 b_inc = 1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(posedge clk); #1;
            if (increment_out) found = 1;
        end
        check("pulse before reset", found, 1);
        rst_n = 0;
        #1 check("outputs in mid-pulse reset", {mode_out, select_out, increment_out, alarm_enable_out, ring_out}, 0);
        b_inc = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (5) @(posedge clk);
        #1 check("mode after reset release", mode_out, 0);

        // mode cycling with a one-cycle glitch that must be rejected
        press(0, 5, 8);
        @(posedge clk); #1 b_mode = 1;
        @(posedge clk); #1 b_mode = 0;
        repeat (8) @(posedge clk);
        press(0, 5, 8);
        press(0, 5, 8);
        press(0, 5, 8);

        // select cycling in CLOCK_EDIT
        press(0, 5, 8);
        for (int i = 0; i < 3; i++) press(1, 5, 8);
        press(0, 5, 8);
        press(0, 5, 8);

        // auto-repeat in ALARM_EDIT, single pulse in STOPWATCH
        press(2, 31, 10);
        press(0, 5, 8);
        press(0, 5, 8);
        press(0, 5, 8);
        press(2, 31, 10);
        press(0, 5, 8);
        press(0, 5, 8);

        // ring: arm, time out, then silence with select in CLOCK_EDIT
        press(2, 5, 8);
        ring(RTO * 1000);
        repeat (RTO * 1000 + 50) @(posedge clk);
        press(0, 5, 8);
        ring(-1);
        repeat (20) @(posedge clk);
        press(1, 5, 8);

        // mode and inc debounced together: mode wins, no pulse
        m_mode = 2; m_sel = 0;
        st_q.push_back(st_pack());
        @(posedge clk); #1 b_mode = 1; b_inc = 1;
        repeat (5) @(posedge clk);
        #1 b_mode = 0; b_inc = 0;
        repeat (10) @(posedge clk);

        for (int i = 0; i < 30; i++)
            press(int'($urandom_range(0, 2)), int'($urandom_range(3, 25)), int'($urandom_range(8, 14)));

        repeat (30) @(posedge clk);
        check("state queue drained", st_q.size(), 0);
        check("pulse queue drained", pulse_q.size(), 0);
        check("ring queue drained", dur_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/clock_ui_controller.md
Name: clock_ui_controller

Overview:
- Front-end controller for the digital clock. Turns three raw push-buttons into the mode, select, increment and alarm-enable controls that drive the clock/stopwatch/alarm datapath.
- Adds alarm ringing/silence sequencing on top of those controls.
- Sits between board buttons and the digital clock top. Owns all user-interface sequencing: debounce, mode cycling, field selection, auto-repeat and ring timeout.

Parameters:
- CLK_FREQ_HZ, 1000: input clock frequency; must be a multiple of 1000 and >= 1000.
- DEBOUNCE_MS, 20: stable-level time required to accept a button change.
- REPEAT_DELAY_MS, 500: hold time before auto-repeat starts.
- REPEAT_RATE_MS, 100: auto-repeat period.
- RING_TIMEOUT_S, 60: maximum ring duration.

Ports:
- clk  in  1  system clock
- global_reset_n  in  1  asynchronous active-low reset
- btn_mode  in  1  raw mode button, asynchronous
- btn_select  in  1  raw field-select button, asynchronous
- btn_inc  in  1  raw increment/start-stop button, asynchronous
- alarm_in  in  1  alarm match level from alarm datapath
- mode_out  out  2  0=CLOCK, 1=CLOCK_EDIT, 2=STOPWATCH, 3=ALARM_EDIT
- select_out  out  2  0=NONE, 1=SEC, 2=MIN, 3=HOUR
- increment_out  out  1  increment pulse to datapath
- alarm_enable_out  out  1  alarm arm level
- ring_out  out  1  buzzer drive

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: mode_out=0, select_out=0, increment_out=0, alarm_enable_out=0, ring_out=0. All counters, synchronizers and debounced levels are cleared to 0. Assertion mid-operation aborts any pulse, repeat or ring immediately.
- ms tick: prescaler counts 0..CLK_FREQ_HZ/1000-1 and asserts a one-cycle tick on wrap. At CLK_FREQ_HZ=1000 the tick is high every cycle.
- Input conditioning:
  - Each button passes through a 2-FF synchronizer.
  - The debounced level changes only after the synchronized level differs from it for DEBOUNCE_MS consecutive ticks. Any bounce restarts the count.
  - A press event is a one-cycle rising edge of the debounced level. Releases generate no event.
- Event priority, one event per cycle:
  - A ring silence event beats mode, which beats select, which beats inc.
  - Lower-priority press events in the same cycle are discarded, not queued.
- Mode FSM:
  - Mode press advances CLOCK -> CLOCK_EDIT -> STOPWATCH -> ALARM_EDIT -> CLOCK.
  - Entering CLOCK_EDIT or ALARM_EDIT sets select_out=HOUR.
  - Entering CLOCK or STOPWATCH sets select_out=NONE.
- Select: in edit modes, a select press cycles HOUR -> MIN -> SEC -> HOUR. Ignored in other modes.
- Increment pulse: increment_out is high for exactly one tick period (CLK_FREQ_HZ/1000 cycles), followed by at least one tick period low. This guarantees a detectable rising edge downstream.
- Inc press by mode:
  - CLOCK: toggles alarm_enable_out. No pulse.
  - STOPWATCH: exactly one pulse per press, no repeat.
  - Edit modes: one pulse at press. While the debounced level stays high, a further pulse fires after REPEAT_DELAY_MS, then every REPEAT_RATE_MS. Release stops repeat at once.
- Repeat abort: a mode or select event cancels auto-repeat. A pulse already in progress completes its length.
- Ringing:
  - A rising edge of alarm_in (synchronized) while alarm_enable_out=1 sets ring_out=1 and clears a seconds counter, which runs off 1000-tick seconds.
  - ring_out clears on any button press event (the silence event, which is consumed and has no other effect), on RING_TIMEOUT_S seconds elapsed, or on alarm_enable_out going 0.
  - An alarm_in edge while already ringing restarts the timeout.
  - Ringing is independent of mode.
- Width rules: all counters are sized by $clog2 of their maximum count, saturating or wrapping only as stated. No counter overflows at maximum parameter values up to 100 MHz.

Test Plan:
- Reset mid-pulse: CLK_FREQ_HZ=1000, DEBOUNCE_MS=2. Assert global_reset_n=0 during an increment pulse -> all outputs 0 immediately. mode_out=0 after release.
- Debounce and mode cycle: 4 clean btn_mode presses (held 5 ms) plus one 1-cycle glitch -> mode_out sequence 1,2,3,0. The glitch produces no change.
- Select cycling: in CLOCK_EDIT, 3 btn_select presses -> select_out 3->2->1->3. Then a mode press -> mode_out=2, select_out=0.
- Auto-repeat: DELAY=10, RATE=4. Hold btn_inc 30 ms in ALARM_EDIT -> pulses at press, +10, +14, +18, +22, +26, +30 ms relative to the debounced edge. No pulse after release. In STOPWATCH, the same hold gives exactly 1 pulse.
- Ring: RING_TIMEOUT_S=2. Inc in CLOCK sets alarm_enable_out=1. An alarm_in rise sets ring_out=1, which clears after 2000 ticks. A second ring silenced by btn_select leaves select_out and mode_out unchanged.
- Simultaneous: btn_mode and btn_inc debounced in the same cycle in CLOCK_EDIT -> mode_out=2, no increment pulse.
